pll_ce_gen: RTL and testbench

//  Parametrised N-channel fractional clock-enable generator driven from one PLL output clock.

---
 rtl/pll_ce_gen.sv | 117 +++++++++++
 tb/tb_pll_ce_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pll_ce_gen.sv
// Fractional clock-enable generator: one phase accumulator per channel,
// glitch-free run-time retune, common resync and a configuration-stable lock flag.
module pll_ce_gen #(
    parameter int                      NUM_CH      = 6,
    parameter int                      ACC_W       = 24,
    parameter int                      LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = '0,
    parameter logic [NUM_CH*ACC_W-1:0] PHASE_INIT  = '0,
    parameter int                      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              resync,
    output logic [NUM_CH-1:0] ce_out,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [ACC_W-1:0] acc     [NUM_CH];
    logic [ACC_W-1:0] inc     [NUM_CH];
    logic [ACC_W-1:0] phase   [NUM_CH];
    logic [ACC_W-1:0] acc_sum [NUM_CH];
    logic [NUM_CH-1:0] carry;

    logic              pend_q;
    logic              pend_bad_q;
    logic [CH_W-1:0]   pend_ch_q;
    logic [ACC_W-1:0]  pend_inc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              accept;
    logic              ch_ok;
    logic              pend_done;
    logic [NUM_CH-1:0] apply_hit;

    assign accept = cfg_valid & cfg_ready;
    assign ch_ok  = 32'(cfg_ch) < 32'(NUM_CH);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            {carry[i], acc_sum[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    // A pending increment lands only where the old one wraps, so no short pulse gap.
    always_comb begin
        apply_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            apply_hit[i] = pend_q && !pend_bad_q
                        && (32'(pend_ch_q) == 32'(i))
                        && (resync || carry[i] || inc[i] == '0);
        end
    end

    assign pend_done = pend_q && (pend_bad_q || resync || (|apply_hit));

    always_comb begin
        cnt_nxt = cnt_q;
        if ((accept && ch_ok) || resync) begin
            cnt_nxt = '0;
        end else if (!(pend_q && !pend_bad_q) && cnt_q < CNT_W'(LOCK_CYCLES)) begin
            cnt_nxt = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]   <= PHASE_INIT[i*ACC_W +: ACC_W];
                inc[i]   <= INC_INIT[i*ACC_W +: ACC_W];
                phase[i] <= PHASE_INIT[i*ACC_W +: ACC_W];
            end
            ce_out     <= '0;
            cfg_ready  <= 1'b1;
            pend_q     <= 1'b0;
            pend_bad_q <= 1'b0;
            pend_ch_q  <= '0;
            pend_inc_q <= '0;
            cnt_q      <= '0;
            locked     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= resync ? phase[i] : acc_sum[i];
                if (apply_hit[i]) begin
                    inc[i] <= pend_inc_q;
                end
                if (accept && ch_ok && 32'(cfg_ch) == 32'(i)) begin
                    phase[i] <= cfg_phase;
                end
            end
            ce_out <= resync ? '0 : carry;

            if (accept) begin
                pend_q     <= 1'b1;
                pend_bad_q <= !ch_ok;
                pend_ch_q  <= cfg_ch;
                pend_inc_q <= cfg_inc;
                cfg_ready  <= 1'b0;
            end else if (pend_done) begin
                pend_q     <= 1'b0;
                pend_bad_q <= 1'b0;
                cfg_ready  <= 1'b1;
            end

            cnt_q  <= cnt_nxt;
            locked <= (cnt_nxt == CNT_W'(LOCK_CYCLES));
        end
    end

endmodule

// File: tb/tb_pll_ce_gen.sv
// Directed bench for pll_ce_gen: 3 channels, 8-bit accumulators, 16-cycle lock.
// ch0 inc=128, ch1 inc=64, ch2 silent (inc=0) out of reset.
module tb_pll_ce_gen;

    logic       refclk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_inc;
    logic [7:0] cfg_phase;
    logic       resync;
    logic [2:0] ce_out;
    logic       locked;

    int total = 0;
    int bad   = 0;

    pll_ce_gen #(
        .NUM_CH      (3),
        .ACC_W       (8),
        .LOCK_CYCLES (16),
        .INC_INIT    ({8'd0, 8'd64, 8'd128}),
        .PHASE_INIT  (24'd0)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .resync    (resync),
        .ce_out    (ce_out),
        .locked    (locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] ch;
        logic [7:0] inc;
        logic [7:0] ph;
        logic       rs;
        logic [2:0] ce;
        logic       rdy;
        logic       lk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [1:0] ch,
                                logic [7:0] n, logic [7:0] p, logic rs,
                                logic [2:0] e, logic y, logic l);
        vec_t t;
        t.r = r; t.v = v; t.ch = ch; t.inc = n; t.ph = p; t.rs = rs;
        t.ce = e; t.rdy = y; t.lk = l;
        return t;
    endfunction

    function automatic vec_t idle(logic [2:0] e, logic y, logic l);
        return mk(1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, e, y, l);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    initial begin
        int pos[$];
        int expp[9];

        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_inc = '0; cfg_phase = '0; resync = 1'b0;
        expp = '{3, 6, 8, 11, 14, 16, 19, 22, 24};

        // reset, then free run to lock
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 1'b1, 1'b0));
        for (int e = 1; e <= 20; e++)
            tbl.push_back(idle({1'b0, e % 4 == 0, e % 2 == 0}, 1'b1, e >= 16));
        // retune ch1 to 128 one cycle after its pulse
        tbl.push_back(mk(1'b0, 1'b1, 2'd1, 8'd128, 8'd0, 1'b0, 3'b000, 1'b0, 1'b0));
        tbl.push_back(idle(3'b001, 1'b0, 1'b0));
        tbl.push_back(idle(3'b000, 1'b0, 1'b0));
        tbl.push_back(idle(3'b011, 1'b1, 1'b0));
        for (int e = 25; e <= 41; e++)
            tbl.push_back(idle((e % 2 == 0) ? 3'b011 : 3'b000, 1'b1, e >= 40));
        // ch1 phase=128, then resync
        tbl.push_back(mk(1'b0, 1'b1, 2'd1, 8'd128, 8'd128, 1'b0, 3'b011, 1'b0, 1'b0));
        tbl.push_back(idle(3'b000, 1'b0, 1'b0));
        tbl.push_back(idle(3'b011, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 3'b000, 1'b1, 1'b0));
        for (int e = 46; e <= 61; e++)
            tbl.push_back(idle((e % 2 == 0) ? 3'b010 : 3'b001, 1'b1, e >= 61));
        // invalid channel keeps lock
        tbl.push_back(mk(1'b0, 1'b1, 2'd3, 8'h55, 8'h77, 1'b0, 3'b010, 1'b0, 1'b1));
        tbl.push_back(idle(3'b001, 1'b1, 1'b1));
        tbl.push_back(idle(3'b010, 1'b1, 1'b1));
        // silent ch2 gets inc=64 on the next edge
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 8'd64, 8'd0, 1'b0, 3'b001, 1'b0, 1'b0));
        tbl.push_back(idle(3'b010, 1'b1, 1'b0));
        tbl.push_back(idle(3'b001, 1'b1, 1'b0));
        tbl.push_back(idle(3'b010, 1'b1, 1'b0));
        tbl.push_back(idle(3'b001, 1'b1, 1'b0));
        tbl.push_back(idle(3'b110, 1'b1, 1'b0));
        // resync and accept on one edge: new phase not used yet
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 8'd128, 8'd128, 1'b1, 3'b000, 1'b0, 1'b0));
        tbl.push_back(idle(3'b010, 1'b0, 1'b0));
        tbl.push_back(idle(3'b001, 1'b1, 1'b0));
        tbl.push_back(idle(3'b010, 1'b1, 1'b0));
        tbl.push_back(idle(3'b101, 1'b1, 1'b0));
        // reset while a cfg is pending
        tbl.push_back(mk(1'b0, 1'b1, 2'd1, 8'd32, 8'd0, 1'b0, 3'b010, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 1'b1, 1'b0));
        for (int e = 1; e <= 8; e++)
            tbl.push_back(idle({1'b0, e % 4 == 0, e % 2 == 0}, 1'b1, 1'b0));

        foreach (tbl[i]) begin
            rst       = tbl[i].r;
            cfg_valid = tbl[i].v;
            cfg_ch    = tbl[i].ch;
            cfg_inc   = tbl[i].inc;
            cfg_phase = tbl[i].ph;
            resync    = tbl[i].rs;
            step();
            chk($sformatf("v%0d ce", i), 32'(ce_out), 32'(tbl[i].ce));
            chk($sformatf("v%0d ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d locked", i), 32'(locked), 32'(tbl[i].lk));
        end

        // ch2 inc=96: pulses 3,3,2 edges apart from a zero phase
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd96; cfg_phase = 8'd0;
        step();
        chk("inc96 accept ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        step();
        chk("inc96 apply ready", 32'(cfg_ready), 32'd1);
        for (int k = 1; k <= 24; k++) begin
            step();
            if (ce_out[2]) pos.push_back(k);
        end
        chk("inc96 pulse count", 32'(pos.size()), 32'd9);
        for (int j = 0; j < 9; j++) begin
            if (j < pos.size())
                chk($sformatf("inc96 pulse%0d", j), 32'(pos[j]), 32'(expp[j]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
